ss_seq: RTL and testbench
=========================

SS_SEQ -- requirements
Module: ss_seq

Interface
REQ-001 SHALL expose parameters, one per line:
- SS_LEN, 18, number of mapper save-state words (ss_addr 0..SS_LEN-1).
- IDX_ADDR, 127, ss_addr of the mapper identity byte (map_idx).
REQ-002 SHALL expose ports, one per line:
- m2  input  1  single clock; all state changes on negedge m2.
- map_rst  input  1  reset, synchronous, active-high.
- cmd_save  input  1  request snapshot, mapper to buffer.
- cmd_load  input  1  request restore, buffer to mapper.
- busy  output  1  high while a sequence runs.
- done  output  1  one-cycle pulse at the end of every accepted command.
- err  output  2  result: 0 ok, 1 identity mismatch, 2 checksum fail, 3 command conflict.
- ss_act  output  1  freezes the mapper and selects the save-state path.
- ss_we  output  1  mapper save-state write strobe.
- ss_addr  output  8  mapper save-state address.
- ss_wdat  output  8  mapper save-state write data.
- ss_rdat  input  8  mapper save-state read data; combinational from ss_addr.
- buf_addr  output  8  snapshot buffer address.
- buf_we  output  1  snapshot buffer write strobe.
- buf_wdat  output  8  snapshot buffer write data.
- buf_rdat  input  8  snapshot buffer read data; valid one cycle after buf_addr.

Function
REQ-003 SHALL store snapshots in this buffer layout: words 0..SS_LEN-1 hold mapper data; word SS_LEN holds map_idx; word SS_LEN+1 holds the checksum.
REQ-004 The checksum SHALL be the sum mod 256 of buffer words 0..SS_LEN.
REQ-005 SHALL implement the states IDLE, SAVE, L_IDX, L_CMP, L_SUM, L_WR and DONE.
REQ-006 Command acceptance SHALL occur only in IDLE; commands arriving in any other state SHALL be ignored.
REQ-007 cmd_save alone in IDLE SHALL enter SAVE with idx=0 and clear err.
REQ-008 cmd_load alone in IDLE SHALL enter L_IDX with idx=0 and clear err.
REQ-009 cmd_save and cmd_load together in IDLE SHALL set err=3, go to DONE and perform no bus activity.
REQ-010 In SAVE, one word SHALL be written per cycle for SS_LEN+2 cycles: buf_we=1, buf_addr=idx.
- idx<SS_LEN: ss_addr=idx, buf_wdat=ss_rdat.
- idx=SS_LEN: ss_addr=IDX_ADDR, buf_wdat=ss_rdat.
- idx=SS_LEN+1: buf_wdat=accumulated sum.
- Sum accumulates each written word for idx 0..SS_LEN.
REQ-011 L_IDX SHALL last one cycle with ss_addr=IDX_ADDR and buf_addr=SS_LEN.
REQ-012 In L_CMP, ss_addr SHALL stay at IDX_ADDR; buf_rdat is compared with ss_rdat; a mismatch SHALL give err=1 and go to DONE; a match SHALL go to L_SUM.
REQ-013 L_SUM SHALL issue buf_addr 0..SS_LEN+1 on consecutive cycles and accumulate buf_rdat one cycle later for words 0..SS_LEN.
REQ-014 On the cycle after the last L_SUM issue, the sum SHALL be compared with word SS_LEN+1; a mismatch SHALL give err=2 and go to DONE; a match SHALL go to L_WR.
REQ-015 L_WR SHALL issue buf_addr i on cycle i for i=0..SS_LEN-1, and drive ss_we=1, ss_addr=i-1, ss_wdat=buf_rdat on cycle i for i=1..SS_LEN; this is SS_LEN+1 cycles in total.
REQ-016 No ss_we SHALL be asserted in any state other than L_WR; err 1 or 2 therefore leaves the mapper state untouched.
REQ-017 ss_act SHALL be 1 in SAVE, L_IDX, L_CMP, L_SUM and L_WR, and 0 in IDLE and DONE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 err SHALL hold its value until the next accepted command.
REQ-021 Outputs SHALL be decoded from registered state and idx only; ss_rdat may be captured through buf_wdat in the same cycle.
REQ-022 idx and the sum SHALL be 8-bit with wrap-around; SS_LEN+1 SHALL be at most 255.

Reset
REQ-023 While map_rst=1 at a clock edge: state=IDLE, idx=0, sum=0, err=0.
REQ-024 Reset SHALL force all outputs to 0: busy, done, ss_act, ss_we, buf_we, ss_addr, ss_wdat, buf_addr and buf_wdat.
REQ-025 Reset mid-sequence SHALL abort at the next edge with no done pulse; a partially written buffer or mapper is acceptable.
REQ-026 Reset SHALL take priority over any command in the same cycle.

Structure
REQ-027 A shared package ss_seq_pkg SHALL hold the state enumeration, the err codes (ERR_OK, ERR_IDX, ERR_SUM, ERR_CMD) and the default SS_LEN/IDX_ADDR constants.
REQ-028 ss_seq SHALL be a single module with no sub-module; the checksum accumulator and FSM are inline.

Verification
REQ-029 Stub mapper ss_rdat=ss_addr[7:0], cmd_save -> buffer[0..17]=0..17, buffer[18]=0x7F, buffer[19]=0x18, done after 20 SAVE cycles, err=0, no ss_we.
REQ-030 Buffer from REQ-029, stub idx 0x7F, cmd_load -> 18 ss_we writes with ss_addr 0..17 and ss_wdat 0..17 in order, done, err=0.
REQ-031 Stub idx changed to 0x42, cmd_load -> err=1, zero ss_we pulses, done one cycle after L_CMP.
REQ-032 buffer[5] corrupted to 0xFF, cmd_load -> err=2, zero ss_we pulses.
REQ-033 cmd_save and cmd_load asserted together -> err=3, done pulse, ss_act never high.
REQ-034 map_rst at SAVE idx=7 -> next edge busy=0, ss_act=0, no done; a following cmd_save completes normally.

Source files
------------

// File: rtl/ss_seq_pkg.sv
// Shared types and defaults for the mapper save-state sequencer.
// Snapshot buffer layout: mapper words, then identity byte, then checksum.
package ss_seq_pkg;

  localparam int SS_LEN_DEF   = 18;
  localparam int IDX_ADDR_DEF = 127;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    L_IDX,
    L_CMP,
    L_SUM,
    L_WR,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK  = 2'd0,
    ERR_IDX = 2'd1,
    ERR_SUM = 2'd2,
    ERR_CMD = 2'd3
  } err_t;

endpackage

// File: rtl/ss_seq_if.sv
// Command/status, mapper save-state bus and snapshot buffer bus of ss_seq.
// The master side is the sequencer; the slave side is the mapper/buffer/host.
interface ss_seq_if;
  import ss_seq_pkg::*;

  logic       cmd_save;
  logic       cmd_load;
  logic       busy;
  logic       done;
  err_t       err;
  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;
  logic [7:0] buf_addr;
  logic       buf_we;
  logic [7:0] buf_wdat;
  logic [7:0] buf_rdat;

  modport master (
    input  cmd_save, cmd_load, ss_rdat, buf_rdat,
    output busy, done, err, ss_act, ss_we, ss_addr, ss_wdat,
           buf_addr, buf_we, buf_wdat
  );

  modport slave (
    output cmd_save, cmd_load, ss_rdat, buf_rdat,
    input  busy, done, err, ss_act, ss_we, ss_addr, ss_wdat,
           buf_addr, buf_we, buf_wdat
  );

endinterface

// File: rtl/ss_seq.sv
// Save/restore sequencer: snapshots mapper state into a buffer with identity
// byte and checksum, and restores it only after both have been verified.
module ss_seq
  import ss_seq_pkg::*;
#(
  parameter int SS_LEN   = SS_LEN_DEF,
  parameter int IDX_ADDR = IDX_ADDR_DEF
) (
  input  logic      m2,
  input  logic      map_rst,
  ss_seq_if.master  bus
);

  localparam logic [7:0] LEN8   = 8'(SS_LEN);
  localparam logic [7:0] LEN_P1 = 8'(SS_LEN + 1);
  localparam logic [7:0] IDX8   = 8'(IDX_ADDR);

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  err_t       err_q, err_d;
  logic       chk_q, chk_d;

  logic       busy_c;
  logic       done_c;
  logic       ss_act_c;
  logic       ss_we_c;
  logic [7:0] ss_addr_c;
  logic [7:0] ss_wdat_c;
  logic [7:0] buf_addr_c;
  logic       buf_we_c;
  logic [7:0] buf_wdat_c;

  always_ff @(negedge m2) begin
    if (map_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      err_q   <= ERR_OK;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
    end
  end

  // chk_q marks the extra L_SUM cycle where the stored checksum arrives,
  // so idx never has to count past SS_LEN+1.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    err_d      = err_q;
    chk_d      = chk_q;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    ss_act_c   = 1'b0;
    ss_we_c    = 1'b0;
    ss_addr_c  = '0;
    ss_wdat_c  = '0;
    buf_addr_c = '0;
    buf_we_c   = 1'b0;
    buf_wdat_c = '0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_save && bus.cmd_load) begin
          err_d   = ERR_CMD;
          state_d = DONE;
        end else if (bus.cmd_save) begin
          err_d   = ERR_OK;
          idx_d   = '0;
          sum_d   = '0;
          state_d = SAVE;
        end else if (bus.cmd_load) begin
          err_d   = ERR_OK;
          idx_d   = '0;
          sum_d   = '0;
          state_d = L_IDX;
        end
      end

      SAVE: begin
        busy_c     = 1'b1;
        ss_act_c   = 1'b1;
        buf_we_c   = 1'b1;
        buf_addr_c = idx_q;
        if (idx_q < LEN8) begin
          ss_addr_c  = idx_q;
          buf_wdat_c = bus.ss_rdat;
        end else if (idx_q == LEN8) begin
          ss_addr_c  = IDX8;
          buf_wdat_c = bus.ss_rdat;
        end else begin
          buf_wdat_c = sum_q;
        end
        if (idx_q == LEN_P1) begin
          state_d = DONE;
        end else begin
          sum_d = sum_q + buf_wdat_c;
          idx_d = idx_q + 8'd1;
        end
      end

      L_IDX: begin
        busy_c     = 1'b1;
        ss_act_c   = 1'b1;
        ss_addr_c  = IDX8;
        buf_addr_c = LEN8;
        state_d    = L_CMP;
      end

      L_CMP: begin
        busy_c    = 1'b1;
        ss_act_c  = 1'b1;
        ss_addr_c = IDX8;
        if (bus.buf_rdat != bus.ss_rdat) begin
          err_d   = ERR_IDX;
          state_d = DONE;
        end else begin
          idx_d   = '0;
          sum_d   = '0;
          chk_d   = 1'b0;
          state_d = L_SUM;
        end
      end

      // Reads lag addresses by one cycle, so word idx-1 is summed at idx.
      L_SUM: begin
        busy_c   = 1'b1;
        ss_act_c = 1'b1;
        if (chk_q) begin
          chk_d = 1'b0;
          if (sum_q != bus.buf_rdat) begin
            err_d   = ERR_SUM;
            state_d = DONE;
          end else begin
            idx_d   = '0;
            state_d = L_WR;
          end
        end else begin
          buf_addr_c = idx_q;
          if (idx_q != 8'd0) begin
            sum_d = sum_q + bus.buf_rdat;
          end
          if (idx_q == LEN_P1) begin
            chk_d = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      L_WR: begin
        busy_c   = 1'b1;
        ss_act_c = 1'b1;
        if (idx_q < LEN8) begin
          buf_addr_c = idx_q;
        end
        if (idx_q != 8'd0) begin
          ss_we_c   = 1'b1;
          ss_addr_c = idx_q - 8'd1;
          ss_wdat_c = bus.buf_rdat;
        end
        if (idx_q == LEN8) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end

      DONE: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.err      = err_q;
  assign bus.ss_act   = ss_act_c;
  assign bus.ss_we    = ss_we_c;
  assign bus.ss_addr  = ss_addr_c;
  assign bus.ss_wdat  = ss_wdat_c;
  assign bus.buf_addr = buf_addr_c;
  assign bus.buf_we   = buf_we_c;
  assign bus.buf_wdat = buf_wdat_c;

endmodule

// File: tb/tb_ss_seq.sv
// Bench for ss_seq: stub mapper and snapshot buffer, with expectations taken
// from a buffer-layout/checksum model and the documented state durations.
module tb_ss_seq;
  import ss_seq_pkg::*;

  localparam int SS_LEN   = 18;
  localparam int IDX_ADDR = 127;

  logic m2 = 1'b0;
  logic map_rst = 1'b1;
  always #5 m2 = ~m2;

  ss_seq_if bus ();

  ss_seq #(.SS_LEN(SS_LEN), .IDX_ADDR(IDX_ADDR)) dut (
    .m2      (m2),
    .map_rst (map_rst),
    .bus     (bus)
  );

  logic [7:0] map_mem [256];
  logic [7:0] buf_mem [256];
  logic [7:0] exp_buf [256];
  logic [7:0] pre_map [256];
  logic [7:0] stub_idx;
  logic [7:0] buf_rd_q;

  int checks = 0;
  int errors = 0;

  int   we_cnt, done_cnt, bwe_cnt;
  logic act_seen;
  logic [7:0] we_addr_q [$];
  logic [7:0] we_dat_q [$];

  assign bus.ss_rdat = (int'(bus.ss_addr) < SS_LEN) ? map_mem[bus.ss_addr] :
                       (int'(bus.ss_addr) == IDX_ADDR) ? stub_idx : bus.ss_addr;
  assign bus.buf_rdat = buf_rd_q;

  // Registered-read buffer and writable mapper, both clocked on negedge m2.
  always @(negedge m2) begin
    buf_rd_q <= buf_mem[bus.buf_addr];
    if (bus.buf_we) buf_mem[bus.buf_addr] = bus.buf_wdat;
    if (bus.ss_we)  map_mem[bus.ss_addr]  = bus.ss_wdat;
  end

  always @(posedge m2) begin
    if (bus.ss_we) begin
      we_cnt++;
      we_addr_q.push_back(bus.ss_addr);
      we_dat_q.push_back(bus.ss_wdat);
    end
    if (bus.buf_we) bwe_cnt++;
    if (bus.done)   done_cnt++;
    if (bus.ss_act) act_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clearMonitor();
    we_cnt = 0; done_cnt = 0; bwe_cnt = 0; act_seen = 1'b0;
    we_addr_q.delete();
    we_dat_q.delete();
  endtask

  // Issues a command at negedge+1, optionally pokes the other command while
  // busy, and returns the number of cycles until done is seen.
  task automatic applyStimulus(input logic save, input logic load, input int poke_at,
                               input int max_cycles, output int cycles);
    clearMonitor();
    bus.cmd_save = save;
    bus.cmd_load = load;
    cycles = 0;
    do begin
      @(negedge m2); #1;
      cycles++;
      bus.cmd_save = load && !save && (cycles == poke_at);
      bus.cmd_load = save && !load && (cycles == poke_at);
    end while (!bus.done && cycles < max_cycles);
    checkOutput("done_seen", 32'(bus.done), 32'd1);
    @(negedge m2); #1;
    bus.cmd_save = 1'b0;
    bus.cmd_load = 1'b0;
  endtask

  function automatic void predictSave();
    int s;
    s = 0;
    for (int i = 0; i < SS_LEN; i++) begin
      exp_buf[i] = map_mem[i];
      s += int'(map_mem[i]);
    end
    exp_buf[SS_LEN] = stub_idx;
    s += int'(stub_idx);
    exp_buf[SS_LEN+1] = 8'(s % 256);
  endfunction

  function automatic int predictLoadErr();
    int s;
    if (exp_buf[SS_LEN] != stub_idx) return 1;
    s = 0;
    for (int i = 0; i <= SS_LEN; i++) s += int'(exp_buf[i]);
    if (8'(s % 256) != exp_buf[SS_LEN+1]) return 2;
    return 0;
  endfunction

  // Cycles from acceptance to the DONE cycle, from the state durations.
  function automatic int loadCycles(input int e);
    if (e == 1) return 2 + 1;
    if (e == 2) return 2 + (SS_LEN + 3) + 1;
    return 2 + (SS_LEN + 3) + (SS_LEN + 1) + 1;
  endfunction

  task automatic saveAndCheck(input string tag, input int poke_at);
    int cyc;
    predictSave();
    applyStimulus(1'b1, 1'b0, poke_at, 100, cyc);
    checkOutput({tag, "_cycles"}, 32'(cyc), 32'(SS_LEN + 3));
    checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
    checkOutput({tag, "_ss_we"}, 32'(we_cnt), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    for (int i = 0; i < SS_LEN + 2; i++)
      checkOutput($sformatf("%s_buf%0d", tag, i), 32'(buf_mem[i]), 32'(exp_buf[i]));
  endtask

  task automatic loadAndCheck(input string tag, input int poke_at);
    int cyc, e;
    for (int i = 0; i < SS_LEN; i++) pre_map[i] = map_mem[i];
    e = predictLoadErr();
    applyStimulus(1'b0, 1'b1, poke_at, 200, cyc);
    checkOutput({tag, "_err"}, 32'(bus.err), 32'(e));
    checkOutput({tag, "_cycles"}, 32'(cyc), 32'(loadCycles(e)));
    checkOutput({tag, "_ss_we"}, 32'(we_cnt), (e == 0) ? 32'(SS_LEN) : 32'd0);
    checkOutput({tag, "_buf_we"}, 32'(bwe_cnt), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_cnt), 32'd1);
    for (int i = 0; i < SS_LEN; i++)
      checkOutput($sformatf("%s_map%0d", tag, i), 32'(map_mem[i]),
                  (e == 0) ? 32'(exp_buf[i]) : 32'(pre_map[i]));
    if (e == 0) begin
      for (int i = 0; i < SS_LEN; i++) begin
        checkOutput($sformatf("%s_wa%0d", tag, i), 32'(we_addr_q[i]), 32'(i));
        checkOutput($sformatf("%s_wd%0d", tag, i), 32'(we_dat_q[i]), 32'(exp_buf[i]));
      end
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_ss_act"}, 32'(bus.ss_act), 32'd0);
    checkOutput({tag, "_ss_we"}, 32'(bus.ss_we), 32'd0);
    checkOutput({tag, "_buf_we"}, 32'(bus.buf_we), 32'd0);
    checkOutput({tag, "_ss_addr"}, 32'(bus.ss_addr), 32'd0);
    checkOutput({tag, "_ss_wdat"}, 32'(bus.ss_wdat), 32'd0);
    checkOutput({tag, "_buf_addr"}, 32'(bus.buf_addr), 32'd0);
    checkOutput({tag, "_buf_wdat"}, 32'(bus.buf_wdat), 32'd0);
  endtask

  initial begin
    int cyc, mode, w, x;
    bus.cmd_save = 1'b0;
    bus.cmd_load = 1'b0;
    stub_idx = 8'h7F;
    for (int i = 0; i < 256; i++) begin
      buf_mem[i] = 8'h00;
      map_mem[i] = 8'(i);
      exp_buf[i] = 8'h00;
    end
    clearMonitor();

    // Reset, with a save request held at the same time.
    repeat (2) @(negedge m2);
    #1;
    bus.cmd_save = 1'b1;
    @(negedge m2); #1;
    checkIdleOutputs("reset");
    checkOutput("reset_err", 32'(bus.err), 32'd0);
    bus.cmd_save = 1'b0;
    map_rst = 1'b0;
    @(negedge m2); #1;
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    $display("[TB] directed save with identity stub");
    saveAndCheck("save0", 0);
    checkOutput("save0_idxword", 32'(buf_mem[SS_LEN]), 32'h7F);
    checkOutput("save0_sumword", 32'(buf_mem[SS_LEN+1]), 32'h18);

    $display("[TB] directed restore");
    for (int i = 0; i < SS_LEN; i++) map_mem[i] = 8'(i) ^ 8'hA5;
    loadAndCheck("load_ok", 0);

    $display("[TB] identity mismatch");
    stub_idx = 8'h42;
    loadAndCheck("load_badidx", 0);
    stub_idx = 8'h7F;

    $display("[TB] checksum failure");
    buf_mem[5] = 8'hFF;
    exp_buf[5] = 8'hFF;
    for (int i = 0; i < SS_LEN; i++) map_mem[i] = 8'hC3;
    loadAndCheck("load_badsum", 0);
    buf_mem[5] = 8'h05;
    exp_buf[5] = 8'h05;

    $display("[TB] command conflict");
    applyStimulus(1'b1, 1'b1, 0, 10, cyc);
    checkOutput("conflict_err", 32'(bus.err), 32'd3);
    checkOutput("conflict_cycles", 32'(cyc), 32'd1);
    checkOutput("conflict_done", 32'(done_cnt), 32'd1);
    checkOutput("conflict_act", 32'(act_seen), 32'd0);
    checkOutput("conflict_ss_we", 32'(we_cnt), 32'd0);
    checkOutput("conflict_buf_we", 32'(bwe_cnt), 32'd0);
    repeat (3) @(negedge m2);
    #1;
    checkOutput("conflict_err_hold", 32'(bus.err), 32'd3);
    checkOutput("conflict_idle", 32'(bus.busy), 32'd0);

    $display("[TB] reset in the middle of a save");
    for (int i = 0; i < SS_LEN; i++) map_mem[i] = 8'(i);
    clearMonitor();
    bus.cmd_save = 1'b1;
    cyc = 0;
    do begin
      @(negedge m2); #1;
      bus.cmd_save = 1'b0;
      cyc++;
    end while (cyc < 8);
    checkOutput("abort_buf_addr", 32'(bus.buf_addr), 32'd7);
    checkOutput("abort_buf_we", 32'(bus.buf_we), 32'd1);
    map_rst = 1'b1;
    @(negedge m2); #1;
    checkIdleOutputs("abort");
    map_rst = 1'b0;
    repeat (3) @(negedge m2);
    #1;
    checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
    saveAndCheck("after_abort", 0);

    $display("[TB] randomized save/restore rounds");
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < SS_LEN; i++) map_mem[i] = 8'($urandom);
      stub_idx = 8'($urandom);
      saveAndCheck($sformatf("rsave%0d", r), $urandom_range(1, SS_LEN));
      mode = $urandom_range(0, 2);
      x = $urandom_range(1, 255);
      if (mode == 1) stub_idx = stub_idx ^ 8'(x);
      if (mode == 2) begin
        w = $urandom_range(0, SS_LEN + 1);
        buf_mem[w] = buf_mem[w] ^ 8'(x);
        exp_buf[w] = exp_buf[w] ^ 8'(x);
      end
      for (int i = 0; i < SS_LEN; i++) map_mem[i] = 8'($urandom);
      loadAndCheck($sformatf("rload%0d", r), $urandom_range(1, SS_LEN));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
